uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Serial transmitter that generates the frame format consumed by the team's UART receive path.
- Frame: start bit, then 5, 7 or 8 data bits sent LSB-first, then one stop bit.
- A bit-period counter sets the baud rate; the data bits are sent by an internal shift register.
- Sits between the packet source and the serial pin.
- Uses the same `data_size` encoding as the receive side, so one configuration register drives both ends.

Parameters:
PERIOD_WIDTH, 14, width of the `bit_period` input and of the internal bit-timing counter.

Ports:
clk  input  1  system clock; single clock domain
n_rst  input  1  reset, asynchronous, active-low
tx_start  input  1  request to send a frame; sampled only while idle
tx_data  input  8  payload; bits [data_size-1:0] are sent
data_size  input  4  data bits per frame: 5, 7 or 8; any other value is treated as 8
bit_period  input  PERIOD_WIDTH  clk cycles per serial bit; 0 is treated as 1
serial_out  output  1  serial line; idles high
tx_busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (async, `n_rst` low):
  - `serial_out`=1, `tx_busy`=0, `tx_done`=0.
  - State returns to IDLE; counters and shift register are cleared.
  - Applies immediately, including mid-frame. The partial frame is abandoned and the line returns high.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `serial_out`=1. If `tx_start`=1 at a clock edge:
    - latch `tx_data`, `data_size` (mapped to N = 5, 7 or 8) and `bit_period` (mapped to P ≥ 1);
    - go to START.
  - START: `serial_out`=0 for P cycles, then go to DATA.
  - DATA: drive the shift-register LSB for P cycles per bit, shifting right after each bit. After N bits, go to STOP.
  - STOP: `serial_out`=1 for P cycles, then go to IDLE.
- Latency: `tx_start` sampled at edge 0 → `serial_out` low from cycle 1.
- Frame duration: (N+2)·P cycles.
- `tx_busy`: high in START, DATA and STOP. Registered; rises with the first cycle of START.
- `tx_done`:
  - Registered; high for exactly one cycle, the first IDLE cycle after STOP.
  - `tx_start` is accepted during that cycle, so back-to-back frames have exactly one idle-high cycle between the stop bit and the next start bit.
- `tx_start` while `tx_busy`=1 is ignored; it is neither queued nor able to corrupt the frame.
- Mid-frame changes to `tx_data`, `data_size` or `bit_period` have no effect; all three are used only as latched at start.
- Bit-timing counter:
  - counts 0..P-1 and is reloaded at each bit boundary;
  - no wrap-around beyond P-1;
  - P = 2^PERIOD_WIDTH-1 must work.
- Bit counter: counts 0..N-1 within DATA only.
- `serial_out` comes straight from a flop; it has no combinational path from any input.

Optional Feature:
UART_TX_PARITY_EN
- When defined: an EVEN parity bit is inserted between the last data bit and the stop bit.
  - The parity bit is the XOR of the N transmitted data bits and is held for P cycles.
  - Extra state PARITY sits between DATA and STOP.
  - Frame duration becomes (N+3)·P cycles.
- When undefined: no PARITY state, no parity logic, and the frame is exactly as described above.

Test Plan:
- Reset, then P=10, N=8, `tx_data`=0xA5, pulse `tx_start` at cycle 0:
  - `serial_out` = 0,1,0,1,0,0,1,0,1,1, each held 10 cycles, over cycles 1–100;
  - `tx_busy` high over cycles 1–100;
  - `tx_done` high at cycle 101 only.
- P=4, `data_size`=5, `tx_data`=0xFF → low for 4 cycles, then high for 24 cycles. Frame = 28 cycles; only 5 data bits are sent.
- Invalid or edge configuration:
  - `data_size`=3 with `tx_data`=0x80 → 8 data bits sent, and the 8th data bit is 1;
  - `bit_period`=0 → every bit lasts 1 cycle.
- `tx_start` held high continuously, P=2, N=7 → every frame is 18 cycles; exactly one idle cycle between frames; `tx_done` pulses once per frame; mid-frame starts ignored.
- Reset mid-DATA: `n_rst` low in the 3rd data bit → `serial_out`=1 and `tx_busy`=0 immediately (asynchronously). After release, the line stays idle until a new `tx_start`.
- With UART_TX_PARITY_EN, P=10, N=8, 0xA5 → parity bit 0 over cycles 91–100, stop over 101–110, `tx_done` at 111. With 0xA4 the parity bit is 1.

Source files
------------

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame transmitter: start, 5/7/8 LSB-first data bits, stop (optional UART_TX_PARITY_EN even parity)
module uart_tx_frame #(
    parameter int PERIOD_WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    tx_start,
    input  logic [7:0]              tx_data,
    input  logic [3:0]              data_size,
    input  logic [PERIOD_WIDTH-1:0] bit_period,
    output logic                    serial_out,
    output logic                    tx_busy,
    output logic                    tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                  state;
    logic [PERIOD_WIDTH-1:0] period_m1;
    logic [PERIOD_WIDTH-1:0] tick_cnt;
    logic [2:0]              bit_cnt;
    logic [2:0]              last_bit;
    logic [7:0]              shreg;
    logic [2:0]              size_m1;
    logic                    bit_end;
`ifdef UART_TX_PARITY_EN
    logic                    parity_q;
    logic [7:0]              data_mask;
`endif

    // Unsupported sizes fall back to 8 bits so a bad register value still yields a full byte.
    always_comb begin
        size_m1 = 3'd7;
        case (data_size)
            4'd5:    size_m1 = 3'd4;
            4'd7:    size_m1 = 3'd6;
            default: size_m1 = 3'd7;
        endcase
    end

`ifdef UART_TX_PARITY_EN
    always_comb begin
        data_mask = 8'hFF >> (3'd7 - size_m1);
    end
`endif

    assign bit_end = (tick_cnt == period_m1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            period_m1  <= '0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            last_bit   <= '0;
            shreg      <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    serial_out <= 1'b1;
                    tick_cnt   <= '0;
                    bit_cnt    <= '0;
                    if (tx_start) begin
                        state      <= START;
                        serial_out <= 1'b0;
                        tx_busy    <= 1'b1;
                        shreg      <= tx_data;
                        last_bit   <= size_m1;
                        // A zero period is stretched to one clock per bit.
                        period_m1  <= (bit_period == '0) ? '0 : bit_period - PERIOD_WIDTH'(1);
`ifdef UART_TX_PARITY_EN
                        parity_q   <= ^(tx_data & data_mask);
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        tick_cnt   <= '0;
                        state      <= DATA;
                        serial_out <= shreg[0];
                        shreg      <= {1'b0, shreg[7:1]};
                    end else begin
                        tick_cnt <= tick_cnt + PERIOD_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        if (bit_cnt == last_bit) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state      <= PARITY;
                            serial_out <= parity_q;
`else
                            state      <= STOP;
                            serial_out <= 1'b1;
`endif
                        end else begin
                            bit_cnt    <= bit_cnt + 3'd1;
                            serial_out <= shreg[0];
                            shreg      <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        tick_cnt <= tick_cnt + PERIOD_WIDTH'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tick_cnt   <= '0;
                        state      <= STOP;
                        serial_out <= 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + PERIOD_WIDTH'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        state    <= IDLE;
                        tx_busy  <= 1'b0;
                        tx_done  <= 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + PERIOD_WIDTH'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= 1'b1;
                    tx_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed self-checking bench for uart_tx_frame
module tb_uart_tx_frame;

    localparam int PW = 14;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [3:0]    data_size;
    logic [PW-1:0] bit_period;
    logic          serial_out;
    logic          tx_busy;
    logic          tx_done;

    int checks = 0;
    int failures = 0;

    uart_tx_frame #(.PERIOD_WIDTH(PW)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .data_size  (data_size),
        .bit_period (bit_period),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expects tx_start to have been sampled at the previous posedge; exp_bits[i] is serial bit i.
    // Returns after sampling the tx_done cycle.
    task automatic frame_chk(input string tag, input logic [10:0] exp_bits, input int nbits, input int p);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < p; c++) begin
                @(negedge clk);
                chk({tag, "_serial"}, {31'b0, serial_out}, {31'b0, exp_bits[b]});
                chk({tag, "_busy"}, {31'b0, tx_busy}, 32'd1);
                chk({tag, "_done_low"}, {31'b0, tx_done}, 32'd0);
            end
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'b0, tx_done}, 32'd1);
        chk({tag, "_busy_end"}, {31'b0, tx_busy}, 32'd0);
        chk({tag, "_idle_high"}, {31'b0, serial_out}, 32'd1);
    endtask

    task automatic launch(input logic [7:0] d, input logic [3:0] s, input logic [PW-1:0] p);
        tx_data    = d;
        data_size  = s;
        bit_period = p;
        tx_start   = 1'b1;
        @(posedge clk);
        #1;
        tx_start   = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, "_idle_serial"}, {31'b0, serial_out}, 32'd1);
        chk({tag, "_idle_busy"}, {31'b0, tx_busy}, 32'd0);
        chk({tag, "_idle_done"}, {31'b0, tx_done}, 32'd0);
    endtask

    initial begin
        n_rst      = 1'b0;
        tx_start   = 1'b0;
        tx_data    = 8'h00;
        data_size  = 4'd8;
        bit_period = '0;
        #12;
        chk("reset_serial", {31'b0, serial_out}, 32'd1);
        chk("reset_busy", {31'b0, tx_busy}, 32'd0);
        chk("reset_done", {31'b0, tx_done}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5, 8 bits, P=10; inputs scrambled after start must not matter
        launch(8'hA5, 4'd8, PW'(10));
        tx_data = 8'h00; data_size = 4'd5; bit_period = PW'(1);
`ifdef UART_TX_PARITY_EN
        frame_chk("a5_p10", 11'b10101001010, 11, 10);
`else
        frame_chk("a5_p10", 11'b01101001010, 10, 10);
`endif
        idle_chk("a5_p10");

`ifdef UART_TX_PARITY_EN
        launch(8'hA4, 4'd8, PW'(2));
        frame_chk("a4_parity", 11'b11101001000, 11, 2);
        idle_chk("a4_parity");
`endif

        // 5-bit frame of 0xFF, P=4: low 4 cycles then high through stop
        launch(8'hFF, 4'd5, PW'(4));
`ifdef UART_TX_PARITY_EN
        frame_chk("ff_n5", 11'b00011111110, 8, 4);
`else
        frame_chk("ff_n5", 11'b00001111110, 7, 4);
`endif
        idle_chk("ff_n5");

        // Illegal size 3 -> 8 bits; 8th data bit of 0x80 is 1
        launch(8'h80, 4'd3, PW'(3));
`ifdef UART_TX_PARITY_EN
        frame_chk("sz3_80", 11'b11100000000, 11, 3);
`else
        frame_chk("sz3_80", 11'b01100000000, 10, 3);
`endif
        idle_chk("sz3_80");

        // bit_period=0 -> one cycle per bit
        launch(8'h5A, 4'd8, PW'(0));
`ifdef UART_TX_PARITY_EN
        frame_chk("p0_5a", 11'b10010110100, 11, 1);
`else
        frame_chk("p0_5a", 11'b01010110100, 10, 1);
`endif
        idle_chk("p0_5a");

        // tx_start held high: back-to-back frames with one idle cycle each
        tx_data    = 8'h33;
        data_size  = 4'd7;
        bit_period = PW'(2);
        tx_start   = 1'b1;
        @(posedge clk);
        #1;
        for (int f = 0; f < 3; f++) begin
`ifdef UART_TX_PARITY_EN
            frame_chk("held_n7", 11'b01001100110, 10, 2);
`else
            frame_chk("held_n7", 11'b00101100110, 9, 2);
`endif
        end
        tx_start = 1'b0;
        idle_chk("held_end");

        // Async reset in the 3rd data bit of 0xA0 (bit 2 = 0), P=4
        launch(8'hA0, 4'd8, PW'(4));
        repeat (14) @(negedge clk);
        chk("rst_pre_serial", {31'b0, serial_out}, 32'd0);
        chk("rst_pre_busy", {31'b0, tx_busy}, 32'd1);
        #1;
        n_rst = 1'b0;
        #1;
        chk("rst_async_serial", {31'b0, serial_out}, 32'd1);
        chk("rst_async_busy", {31'b0, tx_busy}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) idle_chk("rst_after");

        // Line recovers for a fresh frame after reset
        launch(8'hA5, 4'd8, PW'(1));
`ifdef UART_TX_PARITY_EN
        frame_chk("post_rst", 11'b10101001010, 11, 1);
`else
        frame_chk("post_rst", 11'b01101001010, 10, 1);
`endif
        idle_chk("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
